// File: rtl/key_event_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_event_if: event port (valid/ready with key index and event code). Rev 1.0
// ----------------------------------------------------------------------------
interface key_event_if #(
  parameter int IDX_W = 2
);
  logic             evt_valid;
  logic [IDX_W-1:0] evt_key;
  logic [1:0]       evt_code;
  logic             evt_ready;

  modport master (output evt_valid, output evt_key, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_key, input evt_code, output evt_ready);
endinterface
`default_nettype wire

// File: rtl/key_event_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_event_ctrl: per-key SHORT/LONG/REPEAT classifier with round-robin event port. Rev 1.0
// ----------------------------------------------------------------------------
module key_event_ctrl #(
  parameter int NUM_KEYS = 4,
  parameter int IDX_W    = 2,
  parameter int LONG_CYC = 50_000_000,
  parameter int REP_CYC  = 10_000_000,
  parameter int CNT_W    = 26
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [NUM_KEYS-1:0] key_flag,
  input  logic [NUM_KEYS-1:0] key_state,
  input  logic                ovf_clr,
  key_event_if.master         evt,
  output logic [NUM_KEYS-1:0] key_busy,
  output logic [NUM_KEYS-1:0] ovf
);

  localparam logic [1:0] K_IDLE = 2'd0;
  localparam logic [1:0] K_HOLD = 2'd1;
  localparam logic [1:0] K_REP  = 2'd2;

  localparam logic [1:0] c_none   = 2'b00;
  localparam logic [1:0] c_short  = 2'b01;
  localparam logic [1:0] c_long   = 2'b10;
  localparam logic [1:0] c_repeat = 2'b11;

  localparam logic [CNT_W-1:0] c_long_tc = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] c_rep_tc  = CNT_W'(REP_CYC - 1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [IDX_W:0]   c_nk      = (IDX_W+1)'(NUM_KEYS);

  logic [NUM_KEYS-1:0] r_ks;
  logic [NUM_KEYS-1:0] r_pend;
  logic [1:0]          r_pend_code [NUM_KEYS];
  logic [NUM_KEYS-1:0] w_drop;
  logic [NUM_KEYS-1:0] w_gnt;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    w_gnt_idx;
  logic                w_gnt_any;
  logic                w_load;
  logic [IDX_W:0]      w_sum;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_ks <= '1;
    else        r_ks <= key_state;
  end

  generate
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      logic [1:0]       r_st;
      logic [1:0]       w_st_nxt;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_nxt;
      logic             w_rel;
      logic             w_post;
      logic [1:0]       w_code;

      assign w_rel       = ~r_ks[i] & key_state[i];
      assign key_busy[i] = (r_st != K_IDLE);

      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          r_st  <= K_IDLE;
          r_cnt <= '0;
        end else begin
          r_st  <= w_st_nxt;
          r_cnt <= w_cnt_nxt;
        end
      end

      // Release has priority over the terminal count in both hold states.
      always_comb begin
        w_st_nxt = r_st;
        case (r_st)
          K_IDLE:  if (key_flag[i]) w_st_nxt = K_HOLD;
          K_HOLD:  if (w_rel) w_st_nxt = K_IDLE;
                   else if (r_cnt == c_long_tc) w_st_nxt = K_REP;
          K_REP:   if (w_rel) w_st_nxt = K_IDLE;
          default: w_st_nxt = K_IDLE;
        endcase
      end

      always_comb begin
        w_post    = 1'b0;
        w_code    = c_none;
        w_cnt_nxt = r_cnt;
        case (r_st)
          K_IDLE: if (key_flag[i]) w_cnt_nxt = '0;
          K_HOLD: begin
            w_cnt_nxt = r_cnt + c_cnt_one;
            if (w_rel) begin
              w_post = 1'b1;
              w_code = c_short;
            end else if (r_cnt == c_long_tc) begin
              w_post    = 1'b1;
              w_code    = c_long;
              w_cnt_nxt = '0;
            end
          end
          K_REP: begin
            w_cnt_nxt = r_cnt + c_cnt_one;
            if (!w_rel && r_cnt == c_rep_tc) begin
              w_post    = 1'b1;
              w_code    = c_repeat;
              w_cnt_nxt = '0;
            end
          end
          default: w_cnt_nxt = '0;
        endcase
      end

      // A slot being granted this cycle is free for a new post.
      assign w_drop[i] = w_post & r_pend[i] & ~w_gnt[i];

      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          r_pend[i]      <= 1'b0;
          r_pend_code[i] <= c_none;
        end else if (w_post && !w_drop[i]) begin
          r_pend[i]      <= 1'b1;
          r_pend_code[i] <= w_code;
        end else if (w_gnt[i]) begin
          r_pend[i]      <= 1'b0;
        end
      end
    end
  endgenerate

  assign w_load = ~evt.evt_valid | evt.evt_ready;

  // Scan downward so the nearest pending key after r_ptr is the last one written.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    for (int k = NUM_KEYS; k >= 1; k--) begin
      w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_sum >= c_nk) w_sum = w_sum - c_nk;
      if (r_pend[w_sum[IDX_W-1:0]]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_sum[IDX_W-1:0];
      end
    end
  end

  assign w_gnt = (w_load && w_gnt_any) ? (NUM_KEYS'(1) << w_gnt_idx) : '0;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      evt.evt_valid <= 1'b0;
      evt.evt_key   <= '0;
      evt.evt_code  <= c_none;
      r_ptr         <= IDX_W'(NUM_KEYS - 1);
    end else if (w_load) begin
      if (w_gnt_any) begin
        evt.evt_valid <= 1'b1;
        evt.evt_key   <= w_gnt_idx;
        evt.evt_code  <= r_pend_code[w_gnt_idx];
        r_ptr         <= w_gnt_idx;
      end else begin
        evt.evt_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) ovf <= '0;
    else        ovf <= (ovf_clr ? '0 : ovf) | w_drop;
  end

endmodule
`default_nettype wire

// File: tb/tb_key_event_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_key_event_ctrl: directed scoreboard bench for key_event_ctrl. Rev 1.0
// ----------------------------------------------------------------------------
module tb_key_event_ctrl;
  localparam int NUM_KEYS = 4;
  localparam int IDX_W    = 2;
  localparam int LONG_CYC = 20;
  localparam int REP_CYC  = 8;
  localparam int CNT_W    = 5;

  localparam logic [1:0] c_short  = 2'b01;
  localparam logic [1:0] c_long   = 2'b10;
  localparam logic [1:0] c_repeat = 2'b11;

  logic                Clk = 1'b0;
  logic                Rst_n;
  logic [NUM_KEYS-1:0] key_flag;
  logic [NUM_KEYS-1:0] key_state;
  logic                ovf_clr;
  logic [NUM_KEYS-1:0] key_busy;
  logic [NUM_KEYS-1:0] ovf;

  int checks = 0;
  int errors = 0;
  logic [3:0] sb [$];
  logic [3:0] exp_ev;
  int order [3];

  key_event_if #(.IDX_W(IDX_W)) evt ();

  key_event_ctrl #(
    .NUM_KEYS(NUM_KEYS), .IDX_W(IDX_W), .LONG_CYC(LONG_CYC),
    .REP_CYC(REP_CYC), .CNT_W(CNT_W)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .key_flag(key_flag), .key_state(key_state),
    .ovf_clr(ovf_clr), .evt(evt), .key_busy(key_busy), .ovf(ovf)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic samp();
    @(negedge Clk);
  endtask

  task automatic press(input int k);
    key_flag[k]  = 1'b1;
    key_state[k] = 1'b0;
    step();
    key_flag[k]  = 1'b0;
  endtask

  task automatic push(input logic [1:0] key, input logic [1:0] code);
    sb.push_back({key, code});
  endtask

  // Every accepted transfer must match the oldest expected event.
  always @(negedge Clk) begin
    if (Rst_n && evt.evt_valid && evt.evt_ready) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed=%0h expected=none", {evt.evt_key, evt.evt_code});
      end
      if (sb.size() > 0) begin
        exp_ev = sb.pop_front();
        checks++;
        assert ({evt.evt_key, evt.evt_code} === exp_ev) else begin
          errors++;
          $error("FAIL sb_event: observed=%0h expected=%0h", {evt.evt_key, evt.evt_code}, exp_ev);
        end
      end
    end
  end

  initial begin
    Rst_n = 1'b0; key_flag = '0; key_state = '1; ovf_clr = 1'b0; evt.evt_ready = 1'b1;
    samp();
    check("rst_valid", evt.evt_valid, 0);
    check("rst_key",   evt.evt_key, 0);
    check("rst_code",  evt.evt_code, 0);
    check("rst_busy",  key_busy, 0);
    check("rst_ovf",   ovf, 0);
    step(); step(); Rst_n = 1'b1; step();

    // SHORT press on key 1
    press(1);
    repeat (10) step();
    samp();
    check("t1_busy", key_busy, 4'b0010);
    push(2'd1, c_short);
    key_state[1] = 1'b1;
    step(); samp();
    check("t1_early", evt.evt_valid, 0);
    check("t1_idle", key_busy, 0);
    step(); samp();
    check("t1_valid", evt.evt_valid, 1);
    check("t1_key", evt.evt_key, 1);
    check("t1_code", evt.evt_code, c_short);
    step(); samp();
    check("t1_width", evt.evt_valid, 0);
    check("t1_sb", sb.size(), 0);

    // LONG then REPEATs on key 2, release gives nothing
    press(2);
    push(2'd2, c_long); push(2'd2, c_repeat); push(2'd2, c_repeat); push(2'd2, c_repeat);
    for (int k = 2; k <= 48; k++) begin
      step();
      if (k == 45) key_state[2] = 1'b1;
      samp();
      check("t2_valid", evt.evt_valid, (k == 22 || k == 30 || k == 38 || k == 46));
    end
    check("t2_busy", key_busy, 0);
    check("t2_sb", sb.size(), 0);

    // Release coincides with LONG terminal count: SHORT only
    press(0);
    repeat (19) step();
    key_state[0] = 1'b1;
    push(2'd0, c_short);
    step(); samp();
    check("t3_early", evt.evt_valid, 0);
    check("t3_idle", key_busy, 0);
    step(); samp();
    check("t3_valid", evt.evt_valid, 1);
    check("t3_key", evt.evt_key, 0);
    check("t3_code", evt.evt_code, c_short);
    repeat (3) begin
      step(); samp();
      check("t3_no_long", evt.evt_valid, 0);
    end
    check("t3_sb", sb.size(), 0);

    Rst_n = 1'b0; step(); Rst_n = 1'b1; step();

    // Arbitration among keys 0, 1, 3 from the reset pointer
    key_flag = 4'b1011; key_state = 4'b0100;
    step();
    key_flag = '0;
    repeat (3) step();
    key_state = '1;
    push(2'd0, c_short); push(2'd1, c_short); push(2'd3, c_short);
    step();
    order = '{0, 1, 3};
    for (int i = 0; i < 3; i++) begin
      step(); samp();
      check("t4_valid", evt.evt_valid, 1);
      check("t4_key", evt.evt_key, order[i]);
    end
    step(); samp();
    check("t4_drain", evt.evt_valid, 0);
    key_flag = 4'b0011; key_state = 4'b1100;
    step();
    key_flag = '0;
    repeat (3) step();
    key_state = '1;
    push(2'd0, c_short); push(2'd1, c_short);
    step();
    step(); samp();
    check("t4b_key0", evt.evt_key, 0);
    step(); samp();
    check("t4b_key1", evt.evt_key, 1);
    step(); samp();
    check("t4b_drain", evt.evt_valid, 0);
    check("t4_sb", sb.size(), 0);

    // Backpressure, pending REPEAT, dropped REPEAT
    evt.evt_ready = 1'b0;
    press(2);
    push(2'd2, c_long); push(2'd2, c_repeat);
    for (int k = 2; k <= 40; k++) begin
      step(); samp();
      if (k >= 22) check("t5_hold", {evt.evt_valid, evt.evt_key, evt.evt_code}, {1'b1, 2'd2, c_long});
      if (k == 36 || k == 37) check("t5_ovf", ovf, (k == 37) ? 4'b0100 : 4'b0000);
    end
    step();
    evt.evt_ready = 1'b1;
    key_state[2] = 1'b1;
    samp();
    check("t5_still_long", evt.evt_code, c_long);
    step(); samp();
    check("t5_rep_valid", evt.evt_valid, 1);
    check("t5_rep_code", evt.evt_code, c_repeat);
    step(); samp();
    check("t5_drain", evt.evt_valid, 0);
    check("t5_ovf_sticky", ovf, 4'b0100);
    check("t5_sb", sb.size(), 0);
    step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    samp();
    check("t5_ovf_clr", ovf, 0);

    // Asynchronous reset with key 3 repeating and an event stalled
    evt.evt_ready = 1'b0;
    press(3);
    for (int k = 2; k <= 38; k++) begin
      step();
    end
    samp();
    check("t6_pre_valid", evt.evt_valid, 1);
    check("t6_pre_busy", key_busy, 4'b1000);
    check("t6_pre_ovf", ovf, 4'b1000);
    #2 Rst_n = 1'b0;
    #1;
    check("t6_valid", evt.evt_valid, 0);
    check("t6_busy", key_busy, 0);
    check("t6_ovf", ovf, 0);
    key_state = '1;
    evt.evt_ready = 1'b1;
    step(); step();
    Rst_n = 1'b1;
    repeat (10) begin
      step(); samp();
      check("t6_no_stale", evt.evt_valid, 0);
    end
    check("t6_sb", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
- Event controller behind a bank of per-key debounce filters.
- Consumes each filter's one-cycle confirmed-press pulse and stable level, and classifies each key's activity as SHORT press, LONG press or auto-REPEAT.
- Shares one event output port between all keys through a round-robin arbiter with a valid/ready handshake.
- Sits between the key filters and the application/UI logic.

Parameters:
NUM_KEYS, 4, number of keys (≥2).
IDX_W, 2, width of key index; ≥ clog2(NUM_KEYS).
LONG_CYC, 50_000_000, hold cycles from confirmed press to LONG event (1 s at 50 MHz).
REP_CYC, 10_000_000, cycles between REPEAT events while held after LONG.
CNT_W, 26, hold-counter width; must hold max(LONG_CYC, REP_CYC).

Ports:
Clk  input  1  system clock, rising edge.
Rst_n  input  1  reset, asynchronous, active-low.
key_flag  input  NUM_KEYS  per-key one-cycle pulse: debounced press confirmed.
key_state  input  NUM_KEYS  per-key debounced level: 1 released, 0 pressed.
evt_ready  input  1  consumer accepts event when high with evt_valid.
ovf_clr  input  1  one-cycle pulse; clears all ovf bits.
evt_valid  output  1  event available.
evt_key  output  IDX_W  index of key owning the event.
evt_code  output  2  01 SHORT, 10 LONG, 11 REPEAT; 00 never presented valid.
key_busy  output  NUM_KEYS  per-key FSM not in K_IDLE.
ovf  output  NUM_KEYS  sticky: an event for that key was dropped.

Behaviour:
- Reset values: evt_valid=0, evt_key=0, evt_code=0, key_busy=0, ovf=0.
- Internal reset values: all FSMs K_IDLE, counters 0, pending clear, registered key_state copy = all 1, grant pointer = NUM_KEYS-1, so key 0 has first priority.
- Release edge per key: registered copy 0 while current key_state is 1.
- Per-key FSM; each key has its own CNT_W counter:
  - K_IDLE: key_flag → K_HOLD, cnt←0. Otherwise stay.
  - K_HOLD: cnt increments each cycle.
    - Release edge → post SHORT, go to K_IDLE.
    - Else cnt==LONG_CYC-1 → post LONG, cnt←0, go to K_REP.
  - K_REP: cnt increments each cycle.
    - Release edge → K_IDLE, no event.
    - Else cnt==REP_CYC-1 → post REPEAT, cnt←0.
  - Release edge and terminal count in the same cycle: release wins. In K_HOLD this gives SHORT; in K_REP there is no REPEAT.
  - key_flag in K_HOLD or K_REP is ignored.
  - Release edge in K_IDLE is ignored.
- Pending slot, one per key (pend bit + code):
  - A post sets pend on the next edge.
  - If pend is already set and is not being granted in the same cycle, the new event is dropped and ovf[i] is set.
  - If the arbiter grants key i in the same cycle a post for key i occurs, the new post wins: pend stays 1 with the new code.
- Output register and arbiter:
  - Load condition: evt_valid==0 or (evt_valid & evt_ready).
  - When the load condition holds and any pend is set, grant the first pending key searching upward from grant_ptr+1 with wrap. Load evt_key/evt_code, set evt_valid=1, clear that pend, grant_ptr←granted key.
  - When the load condition holds and no pend is set, evt_valid←0.
  - Back-to-back transfers are possible: accept and reload happen in the same cycle.
- Latency: a post in cycle t sets pend at edge t+1. With an idle output, evt_valid rises at edge t+2.
- evt_key and evt_code are held stable while evt_valid=1 and evt_ready=0.
- ovf_clr clears all ovf bits. A drop in the same cycle as ovf_clr still sets its bit; set wins.
- key_busy is combinational from FSM state.
- All state is only reset by Rst_n. Reset asserted mid-hold or with evt_valid high returns everything to reset values immediately (asynchronous); no event is emitted.

Test Plan:
Bench uses NUM_KEYS=4, IDX_W=2, LONG_CYC=20, REP_CYC=8, CNT_W=5.
1. SHORT press: key 1 flag, hold 10 cycles, release, evt_ready=1 → exactly one event: key=1, code=01, evt_valid 2 cycles after the release edge cycle, one cycle wide.
2. LONG + REPEAT: key 2 held 45 cycles after flag → LONG at hold count 20, then REPEAT at 28, 36, 44; release gives no SHORT.
3. Simultaneous release and terminal count: key 0 release edge coincides with cnt==19 → SHORT (01) only; no LONG.
4. Arbitration: keys 0, 1, 3 post in the same cycle, evt_ready=1 → grant order 0, 1, 3 on consecutive cycles. Then keys 0 and 1 post together → order 1, 0 is not required; order is 0, 1 because grant_ptr=3.
5. Backpressure and overflow: evt_ready=0 with a key 2 event held. Key 2 posts LONG then REPEAT → outputs stable; the REPEAT lands in pend. A further REPEAT is dropped → ovf[2]=1. Raise evt_ready → pending REPEAT delivered. ovf_clr → ovf=0.
6. Reset mid-operation: assert Rst_n=0 while key 3 is in K_REP and evt_valid=1 → evt_valid, key_busy and ovf go to 0 immediately. After release of reset, no stale event appears.
